// File: rtl/avm_mport_arbiter.sv
// avm_mport_arbiter
// N-port round-robin arbiter in front of a single Avalon-MM command port.
// It handles single-beat transfers only. One registered command stage drives
// the controller. A read-tag FIFO sends returning read data, in order, back to
// the port that issued the read.
// Optional macro AVM_MPORT_ARB_PRIO0_EN: when defined, port 0 has absolute
// priority, and the round-robin covers only ports 1..N_PORTS-1.
module avm_mport_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8,
  localparam int BE_W     = DATA_W / 8,
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                        avm_clk,
  input  logic                        avm_rst_n,
  input  logic [N_PORTS-1:0]          s_read,
  input  logic [N_PORTS-1:0]          s_write,
  input  logic [N_PORTS*ADDR_W-1:0]   s_addr,
  input  logic [N_PORTS*DATA_W-1:0]   s_wdata,
  input  logic [N_PORTS*BE_W-1:0]     s_be,
  output logic [N_PORTS-1:0]          s_ready,
  output logic [N_PORTS-1:0]          s_rdata_valid,
  output logic [DATA_W-1:0]           s_rdata,
  input  logic                        m_ready,
  output logic                        m_read,
  output logic                        m_write,
  output logic                        m_burstbegin,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  output logic [BE_W-1:0]             m_be,
  output logic                        m_size,
  input  logic                        m_rdata_valid,
  input  logic [DATA_W-1:0]           m_rdata,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        err_unexpected
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  logic [ADDR_W-1:0]  addr_arr  [N_PORTS];
  logic [DATA_W-1:0]  wdata_arr [N_PORTS];
  logic [BE_W-1:0]    be_arr    [N_PORTS];

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic               found;
  logic               grant_ok;
  logic               grant_is_read;
  logic               cmd_free;
  logic               can_push;
  logic [N_PORTS-1:0] eligible;

  logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               do_push;
  logic               do_pop;
  logic [IDX_W-1:0]   head_idx;
  logic [N_PORTS-1:0] rvalid_next;

  // Split the flat per-port buses into arrays so that the granted port can be
  // selected with a single index.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      addr_arr[i]  = s_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = s_wdata[i*DATA_W +: DATA_W];
      be_arr[i]    = s_be[i*BE_W +: BE_W];
    end
  end

  // A read may claim a tag if a slot is free, or if a return frees one in the
  // same cycle.
  assign fifo_empty = (count == '0);
  assign can_push   = (count != FULL_CNT) || m_rdata_valid;
  assign cmd_free   = !(m_read || m_write) || m_ready;
  assign eligible   = s_write | (s_read & {N_PORTS{can_push}});

  // Scan for the first eligible port, starting at the round-robin pointer.
  // With the priority option, port 0 is pulled out of the rotation and always
  // overrides the scan.
  always_comb begin
    int j;
    logic [IDX_W-1:0] idx;
    logic pick;
    j = 0;
    idx = '0;
    pick = 1'b0;
    found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      idx = IDX_W'(j);
      pick = eligible[idx];
`ifdef AVM_MPORT_ARB_PRIO0_EN
      if (idx == '0) pick = 1'b0;
`endif
      if (!found && pick) begin
        found = 1'b1;
        grant_idx = idx;
      end
    end
`ifdef AVM_MPORT_ARB_PRIO0_EN
    if (eligible[0]) begin
      found = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  assign grant_ok      = found && cmd_free && avm_rst_n;
  assign grant_is_read = s_read[grant_idx] && !s_write[grant_idx];
  assign do_push       = grant_ok && grant_is_read;
  assign do_pop        = m_rdata_valid && !fifo_empty;
  assign head_idx      = tag_mem[rd_ptr];

  // One-hot accept strobe back to the granted port.
  always_comb begin
    s_ready = '0;
    if (grant_ok) s_ready[grant_idx] = 1'b1;
  end

  // One-hot data-valid for the port that owns the head tag.
  always_comb begin
    rvalid_next = '0;
    if (do_pop) rvalid_next[head_idx] = 1'b1;
  end

  // The command stage loads on a grant. It holds while the controller stalls
  // and empties when a command is taken and no new grant replaces it.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_burstbegin <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_be         <= '0;
    end else if (grant_ok) begin
      m_read       <= grant_is_read;
      m_write      <= s_write[grant_idx];
      m_burstbegin <= 1'b1;
      m_addr       <= addr_arr[grant_idx];
      m_wdata      <= wdata_arr[grant_idx];
      m_be         <= be_arr[grant_idx];
    end else if (m_ready) begin
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_burstbegin <= 1'b0;
    end
  end

  // After a grant, the round-robin pointer moves to the port just past the
  // winner.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rr_ptr <= '0;
`ifdef AVM_MPORT_ARB_PRIO0_EN
    end else if (grant_ok && (grant_idx != '0)) begin
`else
    end else if (grant_ok) begin
`endif
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // The tag storage needs no reset, because only entries between the
  // pointers are ever read.
  always_ff @(posedge avm_clk) begin
    if (do_push) tag_mem[wr_ptr] <= grant_idx;
  end

  // Tag FIFO pointers and occupancy. A push and a pop in the same cycle leave
  // the count unchanged.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Register the returned data toward the owning port, and latch any return
  // that arrives with no tag outstanding.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      s_rdata_valid  <= '0;
      s_rdata        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      s_rdata_valid <= rvalid_next;
      if (do_pop) s_rdata <= m_rdata;
      if (m_rdata_valid && fifo_empty) err_unexpected <= 1'b1;
    end
  end

  assign outstanding = count;
  assign m_size      = 1'b1;

endmodule

// File: doc/avm_mport_arbiter.md
Name: avm_mport_arbiter

Overview:
- Parametrised N-port Avalon-MM arbiter sitting between several on-chip masters and the single Avalon-MM command port of the LPDDR2 controller, all in the avm_clk domain.
- Round-robin arbitration among ports; single-beat transfers only.
- One registered command stage toward the controller.
- Read-tag FIFO routes returning read data back to the issuing port, in order.

Parameters:
- N_PORTS, 2, number of master ports (2..8).
- ADDR_W, 27, word address width.
- DATA_W, 32, data width, multiple of 8; BE_W = DATA_W/8.
- TAG_DEPTH, 8, maximum outstanding reads; power of 2, at least 2.

Ports:
- avm_clk  in  1  clock.
- avm_rst_n  in  1  asynchronous active-low reset.
- s_read  in  N_PORTS  per-port read request.
- s_write  in  N_PORTS  per-port write request.
- s_addr  in  N_PORTS*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
- s_wdata  in  N_PORTS*DATA_W  per-port write data, same slicing rule.
- s_be  in  N_PORTS*BE_W  per-port byte enables, same slicing rule.
- s_ready  out  N_PORTS  per-port accept strobe (waitrequest_n).
- s_rdata_valid  out  N_PORTS  per-port read-data valid.
- s_rdata  out  DATA_W  read data, broadcast to all ports.
- m_ready  in  1  controller ready.
- m_read  out  1  command: read.
- m_write  out  1  command: write.
- m_burstbegin  out  1  asserted with each command.
- m_addr  out  ADDR_W  command address.
- m_wdata  out  DATA_W  command write data.
- m_be  out  BE_W  command byte enables.
- m_size  out  1  burst count, constant 1.
- m_rdata_valid  in  1  controller read-data valid.
- m_rdata  in  DATA_W  controller read data.
- outstanding  out  log2(TAG_DEPTH)+1  reads in flight.
- err_unexpected  out  1  sticky error: read data arrived with no read outstanding.

Behaviour:
- Reset (async assert, release on avm_clk):
  - m_read, m_write, m_burstbegin, s_ready, s_rdata_valid, err_unexpected = 0.
  - m_addr, m_wdata, m_be, s_rdata = 0.
  - Tag FIFO empty; outstanding = 0; round-robin pointer = port 0.
- Eligibility of port i:
  - Port is eligible if s_write[i] = 1, or s_read[i] = 1 and the tag FIFO is not full.
  - If s_read[i] and s_write[i] are both 1, the write is issued and the read is ignored for that acceptance.
- Command register: free when m_read = m_write = 0, or m_ready = 1 in the current cycle (pass-through reload, no bubble).
- Grant:
  - When the register is free and any port is eligible, choose the first eligible port scanning from rr_ptr upward, wrapping modulo N_PORTS.
  - s_ready[g] = 1 combinationally in that cycle; all other s_ready bits = 0.
  - On the next edge: register loads the command from port g; m_burstbegin = 1; rr_ptr = (g+1) mod N_PORTS.
- Latency: request accepted at cycle t appears on m_* at t+1.
- Command hold: m_* are held stable while m_ready = 0.
- Command clear: on m_ready = 1 with no new grant, m_read, m_write and m_burstbegin clear at the next edge.
- Read tagging:
  - Accepting a read pushes port index g into the tag FIFO.
  - m_rdata_valid = 1 pops the FIFO head h; s_rdata_valid[h] = 1 and s_rdata = m_rdata one cycle later (registered).
- Simultaneous push and pop: allowed at any occupancy, including full; occupancy is unchanged.
- Full FIFO: reads are ineligible; writes still proceed.
- Empty pop: m_rdata_valid with an empty FIFO sets err_unexpected (sticky until reset); no s_rdata_valid is asserted; FIFO pointers do not move.
- outstanding equals FIFO occupancy.
- Mid-operation reset: any in-flight command and all tags are discarded; the controller side is reset by the same avm_rst_n.

Optional Feature:
- Macro: AVM_MPORT_ARB_PRIO0_EN.
- Defined: port 0, when eligible, always wins the grant regardless of rr_ptr. rr_ptr advances only on grants to ports 1..N-1; round-robin among those ports is unchanged.
- Undefined: pure round-robin over all ports.

Test Plan:
- N_PORTS=2; port0 and port1 both write continuously with m_ready=1 -> grants alternate 0,1,0,1; m_addr sequence matches; one command every cycle, no bubbles.
- Port1 reads addr 0x100, then port0 reads addr 0x200; controller returns 0xAAAA then 0xBBBB -> s_rdata_valid[1] with 0xAAAA, then s_rdata_valid[0] with 0xBBBB.
- TAG_DEPTH=8; issue 8 reads with no return -> outstanding = 8; a 9th read stalls (s_ready = 0) while a write from another port is still accepted; one return -> 9th read is accepted in the same or the next cycle.
- m_ready held 0 for 5 cycles with a write pending -> m_* stable for 5 cycles; m_burstbegin stays high; the next grant occurs only in the cycle where m_ready = 1.
- m_rdata_valid pulsed at reset state -> err_unexpected = 1 and stays 1; no s_rdata_valid.
- Assert avm_rst_n = 0 with 3 reads outstanding -> all outputs 0 asynchronously; after release outstanding = 0 and first grant goes to port 0.
